sti_rx: RTL and testbench
=========================

Name: sti_rx

Overview:
- Serial-to-parallel receiver, the far end of the team's serial transmit interface (STI).
- Accepts a framed 1-bit stream (si_data qualified by si_valid) of 8/16/24/32 bits.
- Reassembles each frame into a 32-bit word, extracts the 16-bit payload according to the length, fill, low and bit-order settings, and presents it with a one-cycle strobe.
- Sits in front of the pixel/memory path and also serves as the loopback checker for the transmitter.

Parameters:
- PAYLOAD_W, 16, width of the recovered payload; only the default is supported.
- FRAME_MAX, 32, maximum frame length in bits; only the default is supported.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- si_data  in  1  serial data bit
- si_valid  in  1  high for every bit of a frame; low for at least 1 cycle between frames
- si_end  in  1  last-frame marker, sampled on the frame-closing edge
- cfg_length  in  2  00=8, 01=16, 10=24, 11=32 bits
- cfg_msb  in  1  1: first bit is W[N-1]; 0: first bit is W[0]
- cfg_fill  in  1  24/32-bit payload position select
- cfg_low  in  1  8-bit payload position select
- po_data  out  16  recovered payload
- po_valid  out  1  one-cycle strobe, payload good
- po_err  out  1  one-cycle strobe, frame length error
- po_pad_nz  out  1  qualifies po_valid: pad bits were not all zero
- err_cnt  out  ERR_CNT_W  saturating count of po_err pulses
- rx_done  out  1  sticky, end of stream received

Behaviour:
- Reset (reset=0, asynchronous): every output is 0 and the state is IDLE. The shift register, bit counter and latched configuration are cleared. A partial frame is discarded with no po_err.
- States: IDLE, RECV, DONE.
- IDLE, si_valid=1:
  - Latch cfg_length, cfg_msb, cfg_fill and cfg_low; they are ignored for the rest of the frame.
  - Shift in the first bit, set bit_cnt=1, go to RECV.
- RECV, si_valid=1:
  - Shift in the bit; bit_cnt increments and saturates at 33 (6-bit).
  - cfg_msb=1: shift left, new bit into W[0].
  - cfg_msb=0: shift right into W[31]; at close, W is right-aligned by (32-N).
- RECV, si_valid=0 (closing edge), with N the latched length:
  - bit_cnt==N: register po_data and the pad check, pulse po_valid.
  - otherwise (short or overrun): pulse po_err, increment err_cnt (saturates at all-ones), po_data unchanged.
  - si_end=1: go to DONE and set rx_done. Otherwise go to IDLE.
- Latency: the strobe is high in the cycle after the first cycle in which si_valid is low following the last bit.
- Back-to-back frames: a gap of exactly 1 cycle is supported. The closing edge returns to IDLE, so the next edge can accept a new first bit.
- Extraction from the right-aligned frame word W:
  - N=8: cfg_low=1 gives {W[7:0],8'h00}; cfg_low=0 gives {8'h00,W[7:0]}.
  - N=16: W[15:0].
  - N=24: fill=1 gives W[23:8], pad W[7:0]; fill=0 gives W[15:0], pad W[23:16].
  - N=32: fill=1 gives W[31:16], pad W[15:0]; fill=0 gives W[15:0], pad W[31:16].
  - po_pad_nz=1 when any pad bit is 1; data is still delivered.
- DONE: absorbing. si_valid is ignored, no further strobes, rx_done stays 1. Only reset exits.
- po_valid and po_err are never high in the same cycle.
- po_data holds its value between frames.

Decomposition:
- Shared package sti_pkg:
  - length encoding constants LEN_8, LEN_16, LEN_24, LEN_32;
  - a function mapping a length code to its bit count;
  - the state enum;
  - FRAME_MAX.
- The transmitter shares this package.
- One sub-module, sti_rx_extract: purely combinational. Inputs are W, latched length, fill and low; outputs are payload and pad_nz. The FSM, shift register and counters stay in sti_rx.

Test Plan:
- 8-bit, msb=1, low=0, bits 1,0,1,0,0,1,0,1, then valid low -> po_data=16'h00A5, po_valid for 1 cycle, po_pad_nz=0.
- 16-bit, msb=0, word 16'h1234 sent LSB first -> po_data=16'h1234. Repeat with msb=1 and a 1-cycle gap -> two strobes, both 16'h1234.
- 24-bit, fill=1, msb=1, W=24'hBEEF00 -> po_data=16'hBEEF, pad_nz=0. Same with W=24'hBEEF01 -> pad_nz=1.
- 32-bit, fill=0, msb=1, 31 bits only, then valid low -> po_err pulse, no po_valid, err_cnt=1. Then a 33-bit frame -> err_cnt=2. Force 300 errors -> err_cnt=8'hFF.
- 8-bit frame with si_end=1 on the closing edge -> po_valid and rx_done=1. A following 16-bit frame -> no strobe, rx_done stays 1.
- Assert reset after 10 bits of a 16-bit frame -> all outputs 0 immediately, no po_err. After release, a clean 8-bit frame -> correct po_data.

Source files
------------

// File: rtl/sti_pkg.sv
// Shared definitions for the serial transmit interface (STI) transmitter and receiver.
package sti_pkg;

  localparam int unsigned FRAME_MAX = 32;

  // Frame length codes carried on cfg_length
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RECV = 2'b01,
    DONE = 2'b10
  } sti_state_e;

  // Bit count of a frame for a given length code: 8, 16, 24 or 32
  function automatic logic [5:0] len_bits(input logic [1:0] code);
    return {1'b0, code, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Payload extraction from a right-aligned STI frame word.
module sti_rx_extract
  import sti_pkg::*;
(
  input  logic [31:0] w_i,
  input  logic [1:0]  len_i,
  input  logic        fill_i,
  input  logic        low_i,
  output logic [15:0] payload_o,
  output logic        pad_nz_o
);

  // Select payload bits and OR-reduce the pad bits for the latched length
  always_comb begin
    payload_o = '0;
    pad_nz_o  = 1'b0;
    unique case (len_i)
      LEN_8: begin
        payload_o = low_i ? {w_i[7:0], 8'h00} : {8'h00, w_i[7:0]};
      end
      LEN_16: begin
        payload_o = w_i[15:0];
      end
      LEN_24: begin
        if (fill_i) begin
          payload_o = w_i[23:8];
          pad_nz_o  = |w_i[7:0];
        end else begin
          payload_o = w_i[15:0];
          pad_nz_o  = |w_i[23:16];
        end
      end
      LEN_32: begin
        if (fill_i) begin
          payload_o = w_i[31:16];
          pad_nz_o  = |w_i[15:0];
        end else begin
          payload_o = w_i[15:0];
          pad_nz_o  = |w_i[31:16];
        end
      end
      default: begin
        payload_o = '0;
        pad_nz_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver: frames a 1-bit stream, checks its length
// and presents the extracted 16-bit payload with a one-cycle strobe.
module sti_rx
  import sti_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 16,
  parameter int unsigned FRAME_MAX = sti_pkg::FRAME_MAX,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 si_data,
  input  logic                 si_valid,
  input  logic                 si_end,
  input  logic [1:0]           cfg_length,
  input  logic                 cfg_msb,
  input  logic                 cfg_fill,
  input  logic                 cfg_low,
  output logic [PAYLOAD_W-1:0] po_data,
  output logic                 po_valid,
  output logic                 po_err,
  output logic                 po_pad_nz,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 rx_done
);

  localparam logic [5:0] CNT_SAT = 6'd33;

  sti_state_e            state_q;
  logic [FRAME_MAX-1:0]  w_q, w_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [1:0]            len_q;
  logic                  msb_q;
  logic                  fill_q;
  logic                  low_q;
  logic [PAYLOAD_W-1:0]  po_data_q;
  logic                  po_valid_q;
  logic                  po_err_q;
  logic                  po_pad_nz_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  rx_done_q;

  logic [5:0]            n_bits;
  logic [5:0]            align_sh;
  logic [FRAME_MAX-1:0]  w_aligned;
  logic [PAYLOAD_W-1:0]  payload;
  logic                  pad_nz;

  // Next shift word, saturating bit count, saturating error count and frame alignment
  always_comb begin
    w_d       = msb_q ? {w_q[FRAME_MAX-2:0], si_data} : {si_data, w_q[FRAME_MAX-1:1]};
    cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 6'd1;
    err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
    n_bits    = len_bits(len_q);
    align_sh  = 6'(FRAME_MAX) - n_bits;
    // LSB-first frames fill from the top, so a good frame sits in the upper N bits
    w_aligned = msb_q ? w_q : (w_q >> align_sh);
  end

  sti_rx_extract u_extract (
    .w_i       (w_aligned),
    .len_i     (len_q),
    .fill_i    (fill_q),
    .low_i     (low_q),
    .payload_o (payload),
    .pad_nz_o  (pad_nz)
  );

  // Frame FSM with shift register, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      msb_q       <= 1'b0;
      fill_q      <= 1'b0;
      low_q       <= 1'b0;
      po_data_q   <= '0;
      po_valid_q  <= 1'b0;
      po_err_q    <= 1'b0;
      po_pad_nz_q <= 1'b0;
      err_cnt_q   <= '0;
      rx_done_q   <= 1'b0;
    end else begin
      po_valid_q  <= 1'b0;
      po_err_q    <= 1'b0;
      po_pad_nz_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (si_valid) begin
            len_q  <= cfg_length;
            msb_q  <= cfg_msb;
            fill_q <= cfg_fill;
            low_q  <= cfg_low;
            // Start from a clean word so stale bits never reach the pad check
            w_q    <= cfg_msb ? {{(FRAME_MAX-1){1'b0}}, si_data}
                              : {si_data, {(FRAME_MAX-1){1'b0}}};
            cnt_q  <= 6'd1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (si_valid) begin
            w_q   <= w_d;
            cnt_q <= cnt_d;
          end else begin
            if (cnt_q == n_bits) begin
              po_data_q   <= payload;
              po_pad_nz_q <= pad_nz;
              po_valid_q  <= 1'b1;
            end else begin
              po_err_q  <= 1'b1;
              err_cnt_q <= err_cnt_d;
            end
            if (si_end) begin
              rx_done_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              state_q   <= IDLE;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign po_data   = po_data_q;
  assign po_valid  = po_valid_q;
  assign po_err    = po_err_q;
  assign po_pad_nz = po_pad_nz_q;
  assign err_cnt   = err_cnt_q;
  assign rx_done   = rx_done_q;

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for sti_rx.
module tb_sti_rx;

  logic        clk;
  logic        reset;
  logic        si_data;
  logic        si_valid;
  logic        si_end;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        cfg_fill;
  logic        cfg_low;
  logic [15:0] po_data;
  logic        po_valid;
  logic        po_err;
  logic        po_pad_nz;
  logic [7:0]  err_cnt;
  logic        rx_done;

  int unsigned checks;
  int unsigned failures;

  sti_rx #(
    .PAYLOAD_W (16),
    .FRAME_MAX (32),
    .ERR_CNT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .si_end     (si_end),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .cfg_fill   (cfg_fill),
    .cfg_low    (cfg_low),
    .po_data    (po_data),
    .po_valid   (po_valid),
    .po_err     (po_err),
    .po_pad_nz  (po_pad_nz),
    .err_cnt    (err_cnt),
    .rx_done    (rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive nbits bits of word at negedges, then the closing low cycle; returns at
  // the negedge where the strobe from the closing edge is visible. The config
  // pins are inverted after the first bit to show they were latched.
  task automatic send(input logic [31:0] word, input int unsigned nbits,
                      input logic [1:0] len, input logic msb, input logic fill,
                      input logic low, input logic endb);
    for (int unsigned i = 0; i < nbits; i++) begin
      int idx;
      idx = msb ? int'(nbits) - 1 - int'(i) : int'(i);
      if (i == 0) begin
        cfg_length = len;
        cfg_msb    = msb;
        cfg_fill   = fill;
        cfg_low    = low;
      end else begin
        cfg_length = ~len;
        cfg_msb    = ~msb;
        cfg_fill   = ~fill;
        cfg_low    = ~low;
      end
      si_valid = 1'b1;
      si_data  = (idx >= 0 && idx < 32) ? word[idx] : 1'b0;
      @(negedge clk);
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
    si_end   = endb;
    @(negedge clk);
    si_end   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset      = 1'b0;
    si_data    = 1'b0;
    si_valid   = 1'b0;
    si_end     = 1'b0;
    cfg_length = 2'b00;
    cfg_msb    = 1'b0;
    cfg_fill   = 1'b0;
    cfg_low    = 1'b0;

    #3;
    check("rst_data",  po_data,   32'h0);
    check("rst_valid", po_valid,  32'h0);
    check("rst_err",   po_err,    32'h0);
    check("rst_pad",   po_pad_nz, 32'h0);
    check("rst_cnt",   err_cnt,   32'h0);
    check("rst_done",  rx_done,   32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 8-bit MSB first, low=0
    send(32'hA5, 8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a5_data",  po_data,   32'h00A5);
    check("a5_valid", po_valid,  32'h1);
    check("a5_err",   po_err,    32'h0);
    check("a5_pad",   po_pad_nz, 32'h0);
    @(negedge clk);
    check("a5_strobe_1cyc", po_valid, 32'h0);
    check("a5_hold",        po_data,  32'h00A5);

    // 8-bit low=1 places the byte in the top half
    send(32'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("low_data",  po_data,  32'h3C00);
    check("low_valid", po_valid, 32'h1);

    // 16-bit LSB first then MSB first with a 1-cycle gap
    send(32'h1234, 16, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w16_lsb_data",  po_data,  32'h1234);
    check("w16_lsb_valid", po_valid, 32'h1);
    send(32'h1234, 16, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("w16_msb_data",  po_data,  32'h1234);
    check("w16_msb_valid", po_valid, 32'h1);

    // 24-bit fill=1, pad clean then dirty
    send(32'hBEEF00, 24, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    check("w24_data",  po_data,   32'hBEEF);
    check("w24_pad0",  po_pad_nz, 32'h0);
    send(32'hBEEF01, 24, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    check("w24_data2", po_data,   32'hBEEF);
    check("w24_pad1",  po_pad_nz, 32'h1);
    check("w24_valid", po_valid,  32'h1);
    // 24-bit fill=0, LSB first: pad is the top byte
    send(32'h12ABCD, 24, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w24f0_data", po_data,   32'hABCD);
    check("w24f0_pad",  po_pad_nz, 32'h1);

    // 32-bit fill=1, LSB first
    send(32'hCAFE0000, 32, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    check("w32_data",  po_data,   32'hCAFE);
    check("w32_pad",   po_pad_nz, 32'h0);
    check("w32_valid", po_valid,  32'h1);

    // Short 32-bit frame
    send(32'h7FFFFFFF, 31, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("short_err",   po_err,   32'h1);
    check("short_valid", po_valid, 32'h0);
    check("short_cnt",   err_cnt,  32'h1);
    check("short_hold",  po_data,  32'hCAFE);
    @(negedge clk);
    check("short_err_1cyc", po_err, 32'h0);

    // Overrun 32-bit frame
    send(32'hFFFFFFFF, 33, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("over_err", po_err,  32'h1);
    check("over_cnt", err_cnt, 32'h2);

    // Drive the counter to saturation with 1-bit frames
    for (int k = 0; k < 252; k++) send(32'h1, 1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cnt_254", err_cnt, 32'hFE);
    send(32'h1, 1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cnt_255", err_cnt, 32'hFF);
    for (int k = 0; k < 45; k++) send(32'h1, 1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cnt_sat", err_cnt, 32'hFF);
    check("sat_err", po_err,  32'h1);

    // End-of-stream frame then an ignored frame
    send(32'h5A, 8, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    check("end_data",  po_data,  32'h005A);
    check("end_valid", po_valid, 32'h1);
    check("end_done",  rx_done,  32'h1);
    send(32'hFFFF, 16, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("done_novalid", po_valid, 32'h0);
    check("done_noerr",   po_err,   32'h0);
    check("done_sticky",  rx_done,  32'h1);
    check("done_hold",    po_data,  32'h005A);

    // Leave DONE, then reset in the middle of a 16-bit frame
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cfg_length = 2'b01;
    cfg_msb    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      si_valid = 1'b1;
      si_data  = k[0];
      @(negedge clk);
    end
    #2;
    reset    = 1'b0;
    si_valid = 1'b0;
    #1;
    check("mid_rst_data",  po_data,  32'h0);
    check("mid_rst_cnt",   err_cnt,  32'h0);
    check("mid_rst_done",  rx_done,  32'h0);
    check("mid_rst_valid", po_valid, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_noerr", po_err, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_noerr", po_err, 32'h0);
    send(32'h81, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_rst_data",  po_data,  32'h0081);
    check("post_rst_valid", po_valid, 32'h1);
    check("post_rst_cnt",   err_cnt,  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
